// File: rtl/rps_match_ctrl.sv
// Rock-paper-scissors match master: hides committed moves, runs the
// judge handshake, keeps score and declares the match winner.
module rps_match_ctrl #(
  parameter int WIN_TARGET = 2,
  parameter int REVEAL_CYC = 4,
  parameter int RND_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       p1_move,
  input  logic             p1_commit,
  input  logic [2:0]       p2_move,
  input  logic             p2_commit,
  output logic             judge_req,
  output logic [2:0]       judge_in1,
  output logic [2:0]       judge_in2,
  input  logic             judge_ack,
  input  logic [2:0]       judge_res,
  output logic             p1_locked,
  output logic             p2_locked,
  output logic [1:0]       p1_score,
  output logic [1:0]       p2_score,
  output logic [RND_W-1:0] round_cnt,
  output logic             bad_cmd,
  output logic             match_over,
  output logic [1:0]       winner
);

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    REQ,
    REVEAL,
    DONE
  } state_t;

  localparam int CW = $clog2(REVEAL_CYC) + 1;
  localparam logic [CW-1:0] RLAST = CW'(REVEAL_CYC - 1);
  localparam logic [1:0] WT = 2'(WIN_TARGET);

  state_t        state;
  logic [2:0]    m1;
  logic [2:0]    m2;
  logic [CW-1:0] rcnt;

  function automatic logic onehot(input logic [2:0] m);
    return (m == 3'b001) || (m == 3'b010) || (m == 3'b100);
  endfunction

  // Match FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      m1         <= 3'b000;
      m2         <= 3'b000;
      rcnt       <= '0;
      judge_req  <= 1'b0;
      judge_in1  <= 3'b000;
      judge_in2  <= 3'b000;
      p1_locked  <= 1'b0;
      p2_locked  <= 1'b0;
      p1_score   <= 2'b00;
      p2_score   <= 2'b00;
      round_cnt  <= '0;
      bad_cmd    <= 1'b0;
      match_over <= 1'b0;
      winner     <= 2'b00;
    end else begin
      bad_cmd <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= COLLECT;
            m1         <= 3'b000;
            m2         <= 3'b000;
            judge_in1  <= 3'b000;
            judge_in2  <= 3'b000;
            p1_locked  <= 1'b0;
            p2_locked  <= 1'b0;
            p1_score   <= 2'b00;
            p2_score   <= 2'b00;
            round_cnt  <= '0;
            match_over <= 1'b0;
            winner     <= 2'b00;
          end
        end
        COLLECT: begin
          if (p1_locked && p2_locked) begin
            state     <= REQ;
            judge_req <= 1'b1;
            judge_in1 <= m1;
            judge_in2 <= m2;
          end else begin
            if (p1_commit && !p1_locked) begin
              if (onehot(p1_move)) begin
                m1        <= p1_move;
                p1_locked <= 1'b1;
              end else begin
                bad_cmd <= 1'b1;
              end
            end
            if (p2_commit && !p2_locked) begin
              if (onehot(p2_move)) begin
                m2        <= p2_move;
                p2_locked <= 1'b1;
              end else begin
                bad_cmd <= 1'b1;
              end
            end
          end
        end
        REQ: begin
          if (judge_ack) begin
            case (judge_res)
              3'b100:  p1_score <= p1_score + 2'd1;
              3'b010:  p2_score <= p2_score + 2'd1;
              3'b001:  ;
              default: bad_cmd <= 1'b1;
            endcase
            if (round_cnt != '1)
              round_cnt <= round_cnt + 1'b1;
            judge_req <= 1'b0;
            rcnt      <= '0;
            state     <= REVEAL;
          end
        end
        REVEAL: begin
          if (rcnt == RLAST) begin
            if (p1_score == WT || p2_score == WT) begin
              state      <= DONE;
              match_over <= 1'b1;
              winner     <= (p1_score == WT) ? 2'b01 : 2'b10;
            end else begin
              state     <= COLLECT;
              m1        <= 3'b000;
              m2        <= 3'b000;
              judge_in1 <= 3'b000;
              judge_in2 <= 3'b000;
              p1_locked <= 1'b0;
              p2_locked <= 1'b0;
            end
          end else begin
            rcnt <= rcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rps_match_ctrl.sv
// Self-checking bench for rps_match_ctrl: scoreboarded moves plus a
// small score model driven by the bench-side judge.
module tb_rps_match_ctrl;

  localparam int RC = 4;

  logic       clk = 0;
  logic       rst = 0;
  logic       start = 0;
  logic [2:0] p1_move = 0;
  logic       p1_commit = 0;
  logic [2:0] p2_move = 0;
  logic       p2_commit = 0;
  logic       judge_req;
  logic [2:0] judge_in1;
  logic [2:0] judge_in2;
  logic       judge_ack = 0;
  logic [2:0] judge_res = 0;
  logic       p1_locked;
  logic       p2_locked;
  logic [1:0] p1_score;
  logic [1:0] p2_score;
  logic [3:0] round_cnt;
  logic       bad_cmd;
  logic       match_over;
  logic [1:0] winner;

  rps_match_ctrl #(
    .WIN_TARGET(2),
    .REVEAL_CYC(RC),
    .RND_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .p1_move(p1_move),
    .p1_commit(p1_commit),
    .p2_move(p2_move),
    .p2_commit(p2_commit),
    .judge_req(judge_req),
    .judge_in1(judge_in1),
    .judge_in2(judge_in2),
    .judge_ack(judge_ack),
    .judge_res(judge_res),
    .p1_locked(p1_locked),
    .p2_locked(p2_locked),
    .p1_score(p1_score),
    .p2_score(p2_score),
    .round_cnt(round_cnt),
    .bad_cmd(bad_cmd),
    .match_over(match_over),
    .winner(winner)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] in1;
    logic [2:0] in2;
  } exp_t;

  exp_t       sb[$];
  int         n_chk = 0;
  int         n_err = 0;
  logic [1:0] ms1 = 0;
  logic [1:0] ms2 = 0;
  logic [3:0] mrc = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic commit(input logic [2:0] a, input logic ca,
                        input logic [2:0] b, input logic cb);
    p1_move = a;
    p1_commit = ca;
    p2_move = b;
    p2_commit = cb;
    tick();
    p1_commit = 0;
    p2_commit = 0;
  endtask

  task automatic finish_round(input logic [2:0] res, input int hold);
    exp_t e;
    logic bad;
    for (int i = 0; i < 8; i++) begin
      if (judge_req) break;
      chk("hidden1", 32'(judge_in1), 0);
      tick();
    end
    chk("req_seen", 32'(judge_req), 1);
    e = sb.pop_front();
    chk("in1_req", 32'(judge_in1), 32'(e.in1));
    chk("in2_req", 32'(judge_in2), 32'(e.in2));
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("req_hold", 32'(judge_req), 1);
    end
    judge_res = res;
    judge_ack = 1;
    tick();
    judge_ack = 0;
    bad = !(res == 3'b100 || res == 3'b010 || res == 3'b001);
    if (res == 3'b100) ms1++;
    if (res == 3'b010) ms2++;
    if (mrc != 4'hf) mrc++;
    chk("req_drop", 32'(judge_req), 0);
    chk("p1_score", 32'(p1_score), 32'(ms1));
    chk("p2_score", 32'(p2_score), 32'(ms2));
    chk("round_cnt", 32'(round_cnt), 32'(mrc));
    chk("bad_res", 32'(bad_cmd), 32'(bad));
    for (int i = 0; i < RC - 1; i++) tick();
    chk("in1_reveal", 32'(judge_in1), 32'(e.in1));
    chk("in2_reveal", 32'(judge_in2), 32'(e.in2));
    chk("over_early", 32'(match_over), 0);
    tick();
    if (ms1 == 2 || ms2 == 2) begin
      chk("match_over", 32'(match_over), 1);
      chk("winner", 32'(winner), (ms1 == 2) ? 1 : 2);
      chk("in1_done", 32'(judge_in1), 32'(e.in1));
    end else begin
      chk("p1_unlock", 32'(p1_locked), 0);
      chk("p2_unlock", 32'(p2_locked), 0);
      chk("in1_clr", 32'(judge_in1), 0);
      chk("in2_clr", 32'(judge_in2), 0);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req"}, 32'(judge_req), 0);
    chk({tag, "_in"}, 32'({judge_in1, judge_in2}), 0);
    chk({tag, "_lk"}, 32'({p1_locked, p2_locked}), 0);
    chk({tag, "_sc"}, 32'({p1_score, p2_score}), 0);
    chk({tag, "_rc"}, 32'(round_cnt), 0);
    chk({tag, "_mo"}, 32'({bad_cmd, match_over, winner}), 0);
  endtask

  initial begin
    rst = 1;
    tick();
    tick();
    rst = 0;
    chk_zero("reset");
    start = 1;
    tick();
    start = 0;
    chk_zero("start");

    // same-cycle commits, p1 wins
    commit(3'b001, 1, 3'b100, 1);
    sb.push_back('{in1: 3'b001, in2: 3'b100});
    chk("lk_both", 32'({p1_locked, p2_locked}), 3);
    chk("hide_c", 32'({judge_in1, judge_in2}), 0);
    chk("no_req", 32'(judge_req), 0);
    finish_round(3'b100, 0);

    // first commit wins; draw
    commit(3'b010, 1, 3'b000, 0);
    chk("lk_p1", 32'({p1_locked, p2_locked}), 2);
    commit(3'b001, 1, 3'b100, 1);
    sb.push_back('{in1: 3'b010, in2: 3'b100});
    chk("hide_2", 32'({judge_in1, judge_in2}), 0);
    finish_round(3'b001, 0);

    // non-one-hot commit
    commit(3'b000, 0, 3'b011, 1);
    chk("bad_pulse", 32'(bad_cmd), 1);
    chk("p2_nolock", 32'(p2_locked), 0);
    tick();
    chk("bad_end", 32'(bad_cmd), 0);
    commit(3'b001, 1, 3'b010, 1);
    sb.push_back('{in1: 3'b001, in2: 3'b010});
    finish_round(3'b010, 0);

    // invalid verdict
    commit(3'b100, 1, 3'b100, 1);
    sb.push_back('{in1: 3'b100, in2: 3'b100});
    finish_round(3'b111, 0);

    // p2 reaches target
    commit(3'b100, 1, 3'b001, 1);
    sb.push_back('{in1: 3'b100, in2: 3'b001});
    finish_round(3'b010, 0);
    commit(3'b001, 1, 3'b001, 1);
    tick();
    chk("done_hold", 32'({p1_score, p2_score}), 32'({2'd1, 2'd2}));
    chk("done_nolk", 32'(judge_req), 0);

    start = 1;
    tick();
    start = 0;
    ms1 = 0;
    ms2 = 0;
    mrc = 0;
    chk_zero("restart");

    // long hold, then reset while requesting
    commit(3'b010, 1, 3'b001, 1);
    sb.push_back('{in1: 3'b010, in2: 3'b001});
    begin
      exp_t e;
      for (int i = 0; i < 8; i++) begin
        if (judge_req) break;
        tick();
      end
      chk("req2_seen", 32'(judge_req), 1);
      e = sb.pop_front();
      chk("in1_req2", 32'(judge_in1), 32'(e.in1));
      for (int i = 0; i < 20; i++) tick();
      chk("req_20", 32'(judge_req), 1);
    end
    rst = 1;
    tick();
    rst = 0;
    chk_zero("midrst");
    commit(3'b001, 1, 3'b001, 1);
    chk("idle_nolk", 32'({p1_locked, p2_locked}), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
